// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity checker and any matching generator.
package parity_pkg;

  // Receiver FSM: collect the data bits, then wait for the single parity bit.
  typedef enum logic [0:0] {
    S_DATA   = 1'b0,
    S_PARITY = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 4;
  localparam int DEF_CNT_WIDTH  = 8;

  // Parity-mode selectors for the ODD_PARITY parameter.
  localparam bit EVEN = 1'b0;
  localparam bit ODD  = 1'b1;

endpackage : parity_pkg

// File: rtl/parity_xor_reduce.sv
// XOR reduction over a data word plus its parity bit; shared with the generator side.
module parity_xor_reduce #(
  parameter int N = 5
) (
  input  logic [N-1:0] bits,
  output logic         parity
);

  assign parity = ^bits;

endmodule : parity_xor_reduce

// File: rtl/parity_checker.sv
// Serial parity checker: receives DATA_WIDTH data bits LSB first followed by one
// parity bit, reports each completed frame and keeps a saturating error count.
module parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit ODD_PARITY = EVEN,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  din,
  input  logic                  din_valid,
  input  logic                  sync,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_valid,
  output logic                  parity_err,
  output logic [CNT_WIDTH-1:0]  err_count
);

  // bit_cnt counts up to DATA_WIDTH before being cleared by the parity bit.
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  frame_done;
  logic                  xor_all;
  logic                  frame_err;

  // Parity of the collected data bits together with the incoming parity bit.
  parity_xor_reduce #(
    .N (DATA_WIDTH + 1)
  ) u_xor (
    .bits   ({din, shreg_q}),
    .parity (xor_all)
  );

  assign frame_err = xor_all ^ ODD_PARITY;

  // FSM state, bit counter and shift register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (reset) begin
      state_q   <= S_DATA;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  // Next-state logic; sync overrides any bit accepted in the same cycle.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    frame_done = 1'b0;

    if (sync) begin
      state_d   = S_DATA;
      bit_cnt_d = '0;
    end else if (din_valid) begin
      unique case (state_q)
        S_DATA: begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_cnt_q == BW'(i)) shreg_d[i] = din;
          end
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = S_PARITY;
        end
        S_PARITY: begin
          frame_done = 1'b1;
          state_d    = S_DATA;
          bit_cnt_d  = '0;
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  // Registered frame outputs, one clock after the parity bit is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out    <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      parity_err  <= frame_done & frame_err;
      if (frame_done) data_out <= shreg_q;
    end
  end

  // Saturating error counter; a clear beats a coincident error frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (frame_done && frame_err && (err_count != '1)) begin
      err_count <= err_count + CNT_WIDTH'(1);
    end
  end

endmodule : parity_checker

// File: tb/tb_parity_checker.sv
// Scoreboard bench: an even- and an odd-parity checker share the same stimulus;
// expected frames are queued as they are driven and popped on frame_valid.
module tb_parity_checker;

  logic       clk = 1'b0;
  logic       reset, din, din_valid, sync, err_clr;
  logic [3:0] data_e, data_o;
  logic       fv_e, fv_o, perr_e, perr_o;
  logic [7:0] cnt_e, cnt_o;

  typedef struct {
    logic [3:0] data;
    logic       perr_e;
    logic       perr_o;
    logic [7:0] cnt_e;
    logic [7:0] cnt_o;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Bench-side reference model state.
  int         m_cnt = 0;
  logic [3:0] m_data = '0;
  logic [7:0] m_ce = '0, m_co = '0;
  logic [3:0] m_last = '0;

  always #5 clk = ~clk;

  parity_checker #(.DATA_WIDTH(4), .ODD_PARITY(1'b0), .CNT_WIDTH(8)) dut_even (
    .clk (clk), .reset (reset), .din (din), .din_valid (din_valid),
    .sync (sync), .err_clr (err_clr), .data_out (data_e),
    .frame_valid (fv_e), .parity_err (perr_e), .err_count (cnt_e)
  );

  parity_checker #(.DATA_WIDTH(4), .ODD_PARITY(1'b1), .CNT_WIDTH(8)) dut_odd (
    .clk (clk), .reset (reset), .din (din), .din_valid (din_valid),
    .sync (sync), .err_clr (err_clr), .data_out (data_o),
    .frame_valid (fv_o), .parity_err (perr_o), .err_count (cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: compare every frame_valid pulse against the scoreboard head.
  always @(negedge clk) begin
    if (fv_e) begin
      if (sb.size() == 0) begin
        check("spurious_frame_valid", fv_e, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_even", data_e, e.data);
        check("perr_even", perr_e, e.perr_e);
        check("cnt_even",  cnt_e,  e.cnt_e);
        check("fv_odd",    fv_o,   1'b1);
        check("data_odd",  data_o, e.data);
        check("perr_odd",  perr_o, e.perr_o);
        check("cnt_odd",   cnt_o,  e.cnt_o);
      end
    end else begin
      check("perr_idle_even", perr_e, 1'b0);
      check("fv_idle_odd",    fv_o,   1'b0);
    end
  end

  // Drive one din_valid beat (optionally with sync/err_clr) and update the model.
  task automatic send_bit(input logic b, input int gap = 0,
                          input logic do_sync = 1'b0, input logic do_clr = 1'b0);
    logic pe;
    repeat (gap) @(posedge clk);
    #1;
    din = b; din_valid = 1'b1; sync = do_sync; err_clr = do_clr;
    if (do_sync) begin
      m_cnt = 0;
      if (do_clr) begin m_ce = '0; m_co = '0; end
    end else if (m_cnt < 4) begin
      m_data[m_cnt] = b;
      m_cnt++;
      if (do_clr) begin m_ce = '0; m_co = '0; end
    end else begin
      pe = (^m_data) ^ b;
      if (pe && m_ce != 8'hff) m_ce = m_ce + 8'd1;
      if (!pe && m_co != 8'hff) m_co = m_co + 8'd1;
      if (do_clr) begin m_ce = '0; m_co = '0; end
      sb.push_back('{data: m_data, perr_e: pe, perr_o: ~pe, cnt_e: m_ce, cnt_o: m_co});
      m_last = m_data;
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0; sync = 1'b0; err_clr = 1'b0; din = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic p, input int max_gap = 0);
    for (int i = 0; i < 4; i++) send_bit(d[i], $urandom_range(0, max_gap));
    send_bit(p, $urandom_range(0, max_gap));
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cnt = 0; m_data = '0; m_ce = '0; m_co = '0; m_last = '0;
    check("rst_data",  data_e, 4'h0);
    check("rst_fv",    fv_e,   1'b0);
    check("rst_perr",  perr_e, 1'b0);
    check("rst_count", cnt_e,  8'h00);
  endtask

  initial begin
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; sync = 1'b0; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Good frame 1,0,1,1 + parity 1, then the same frame with a bad parity bit.
    send_frame(4'b1101, 1'b1);
    send_frame(4'b1101, 1'b0);

    // Gapped frame 0,1,1,0 + parity 0.
    send_frame(4'b0110, 1'b0, 3);
    repeat (4) @(posedge clk);

    // Resync after three bits, then a full frame 1,1,1,1 + parity 0.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #1 sync = 1'b1;
    @(posedge clk);
    #1 sync = 1'b0;
    m_cnt = 0;
    send_frame(4'b1111, 1'b0);

    // Sync on the parity beat: no frame, data_out holds.
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    send_bit(1'b1, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1 check("hold_data", data_e, m_last);

    // Saturation, then clear.
    for (int i = 0; i < 300; i++) send_frame(4'b1101, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1 check("sat_count", cnt_e, 8'hff);
    err_clr = 1'b1;
    m_ce = '0; m_co = '0;
    @(posedge clk);
    #1 err_clr = 1'b0;
    check("clr_count", cnt_e, 8'h00);

    // Clear coinciding with an error frame: clear wins.
    send_frame(4'b1101, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(m_data[i]);
    send_bit(1'b0, 0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);

    // Reset mid-frame, then 0,0,0,1 + parity 1.
    send_bit(1'b1); send_bit(1'b1);
    do_reset();
    send_frame(4'b1000, 1'b1);

    repeat (4) @(posedge clk);
    #1 check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_parity_checker
